ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the value driven on id_instr when the IF/ID register is empty or squashed.
REQ-003 CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  is the reset, asynchronous and active-high.
REQ-005 stall  input  1  is the downstream hold request; when high, the IF/ID register and fetch PC hold.
REQ-006 redirect  input  1  is the branch/jump taken pulse; it flushes the pipe and refetches.
REQ-007 redirect_pc  input  32  is the redirect target byte address; bits [1:0] are ignored and treated as 00.
REQ-008 rom_addr  output  32  is the combinational byte address presented to the synchronous instruction ROM; the ROM samples it on the rising edge and returns data the following cycle.
REQ-009 rom_data  input  32  is the ROM read data for the address sampled at the previous rising edge.
REQ-010 id_valid  output  1  is high when id_instr/id_pc hold a real instruction.
REQ-011 id_instr  output  32  is the registered instruction for decode.
REQ-012 id_pc  output  32  is the registered byte address of id_instr.
REQ-013 id_pc4  output  32  is id_pc + 4, modulo 2^32.
REQ-014 icount  output  32  is the count of instructions delivered (id_valid load events), wrapping modulo 2^32.

Function
REQ-015 Internal state: pc_q (32-bit in-flight address), inflight_v (1-bit; ROM holds a sampled request), and the IF/ID register (id_valid, id_instr, id_pc).
REQ-016 rom_addr priority: redirect -> {redirect_pc[31:2],2'b00}; else !inflight_v -> pc_q; else stall -> pc_q (reissue, so rom_data stays stable); else pc_q + 4.
REQ-017 On every edge, pc_q loads rom_addr and inflight_v is set to 1.
REQ-018 IF/ID update priority: redirect -> id_valid=0, id_instr=NOP_INSTR, id_pc unchanged; else stall -> hold all; else id_valid=inflight_v, id_instr=(inflight_v ? rom_data : NOP_INSTR), id_pc=pc_q.
REQ-019 Redirect has priority over stall in the same cycle.
REQ-020 Redirect latency: redirect high in cycle n -> target instruction on id_* with id_valid=1 from cycle n+2; the two instructions in flight are discarded.
REQ-021 Sequential throughput: one instruction per cycle with no stall; id_pc increments by 4 each cycle.
REQ-022 Stall: no instruction is lost or duplicated; after stall falls, the next delivered id_pc is the held id_pc + 4.
REQ-023 pc_q + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-024 icount increments by 1 on each edge where the IF/ID register loads with inflight_v=1 (no redirect, no stall).
REQ-025 Asserting redirect in the first cycle after reset release is honoured: the target replaces RESET_PC.

Reset
REQ-026 While RST is high: pc_q=RESET_PC, inflight_v=0, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC, icount=0, and rom_addr=RESET_PC.
REQ-027 Reset asserted mid-operation takes effect immediately, without waiting for a clock edge; in-flight and IF/ID contents are discarded.
REQ-028 After RST falls, first edge: ROM samples RESET_PC; second edge: id_valid=1, id_pc=RESET_PC.

Verification
ROM model: word i holds 32'h1000_0000 + i (addresses aliased on addr[7:2]).
REQ-029 Reset release, stall=0, redirect=0 -> id_valid rises on 2nd edge; id_pc = 0, 4, 8, 12 on consecutive cycles; id_instr = 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003; icount = 1, 2, 3, 4.
REQ-030 stall high for 3 cycles while id_pc=8 -> id_pc/id_instr hold 8/32'h1000_0002 and rom_addr holds 12; icount holds; after release id_pc=12, id_instr=32'h1000_0003.
REQ-031 redirect=1 with redirect_pc=32'h0000_0043 while id_pc=4 -> next cycle id_valid=0 and id_instr=NOP_INSTR; cycle after that id_pc=32'h40, id_instr=32'h1000_0010; then id_pc=32'h44.
REQ-032 redirect and stall both high for one cycle -> the redirect is taken exactly as in the previous scenario; the stall is ignored.
REQ-033 redirect_pc=32'hFFFF_FFFC, then free-run -> id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 RST pulsed asynchronously between edges mid-stream -> outputs take reset values immediately, before the next edge; after release the sequence restarts at RESET_PC with icount=0.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch stage: drives a synchronous ROM and registers the IF/ID stage.
// Latency: two edges from reset release or redirect to the first valid id_* word,
//   then one instruction per cycle.
// Backpressure: stall holds pc_q and IF/ID and reissues the same ROM address.
//   Redirect overrides stall.
// Ports: CLK/RST (async active-high), stall, redirect/redirect_pc in;
//        rom_addr out / rom_data in; id_valid/id_instr/id_pc/id_pc4/icount out.
module ins_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] icount
);

  logic [31:0] pc_q;        // address the ROM is currently returning data for
  logic        inflight_v;  // ROM holds a sampled request
  logic [31:0] target;

  // Word-align the redirect target; the low two bits carry no meaning.
  assign target = redirect_pc & ~32'h0000_0003;

  // ROM address selection. While stalled the in-flight address is reissued so
  // rom_data stays valid for the held request. Before the first request after
  // reset, pc_q itself is issued.
  always_comb begin
    if (RST)
      rom_addr = RESET_PC;
    else if (redirect)
      rom_addr = target;
    else if (!inflight_v || stall)
      rom_addr = pc_q;
    else
      rom_addr = pc_q + 32'd4;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      inflight_v <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= RESET_PC;
      icount     <= 32'd0;
    end else begin
      // Every edge issues a ROM request, so from here on something is in flight.
      pc_q       <= rom_addr;
      inflight_v <= 1'b1;
      if (redirect) begin
        // Squash the word in IF/ID. The ROM is already fetching the target.
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else if (!stall) begin
        id_valid <= inflight_v;
        id_instr <= inflight_v ? rom_data : NOP_INSTR;
        id_pc    <= pc_q;
        if (inflight_v)
          icount <= icount + 32'd1;
      end
    end
  end

  assign id_pc4 = id_pc + 32'd4;

endmodule

// File: tb/tb_ins_fetch.sv
module tb_ins_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4, icount;

  int checks = 0;
  int errors = 0;

  ins_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc4(id_pc4), .icount(icount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {26'd0, a[7:2]};
  endfunction

  // Synchronous ROM: samples the address on the edge, returns data next cycle.
  always @(posedge CLK) rom_data <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a stream of sequential addresses starting at
  // m_next. Deliveries begin once the first request is in flight (primed).
  // A redirect restarts the stream and inserts one bubble. A stall freezes everything.
  logic        m_primed = 1'b0;
  logic [31:0] m_next   = RPC;
  logic        m_valid  = 1'b0;
  logic [31:0] m_instr  = NOP;
  logic [31:0] m_pc     = RPC;
  logic [31:0] m_cnt    = 32'd0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_primed <= 1'b0; m_next <= RPC; m_valid <= 1'b0;
      m_instr <= NOP; m_pc <= RPC; m_cnt <= 32'd0;
    end else if (redirect) begin
      m_valid  <= 1'b0;
      m_instr  <= NOP;
      m_next   <= {redirect_pc[31:2], 2'b00};
      m_primed <= 1'b1;
    end else if (stall) begin
      m_primed <= 1'b1;
    end else if (m_primed) begin
      m_valid <= 1'b1;
      m_instr <= rom_word(m_next);
      m_pc    <= m_next;
      m_cnt   <= m_cnt + 1;
      m_next  <= m_next + 4;
    end else begin
      m_valid  <= 1'b0;
      m_instr  <= NOP;
      m_pc     <= m_next;
      m_primed <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_addr();
    if (RST) return RPC;
    if (redirect) return {redirect_pc[31:2], 2'b00};
    if (!m_primed || stall) return m_next;
    return m_next + 4;
  endfunction

  always @(negedge CLK) begin
    chk("rom_addr", rom_addr, exp_addr());
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_pc);
    chk("id_pc4", id_pc4, m_pc + 4);
    chk("icount", icount, m_cnt);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1 RST = 1'b1;
    #2;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_cnt", icount, 32'd0);
    repeat (3) step();
    RST = 1'b0;
    // Sequential run from reset.
    step(); chk("seq_v0", {31'd0, id_valid}, 32'd0);
    step(); chk("seq_pc0", id_pc, 32'h0); chk("seq_i0", id_instr, 32'h1000_0000);
            chk("seq_c0", icount, 32'd1);
    step(); chk("seq_pc1", id_pc, 32'h4); chk("seq_i1", id_instr, 32'h1000_0001);
    step(); chk("seq_pc2", id_pc, 32'h8); chk("seq_c2", icount, 32'd3);
    // Stall for three cycles while id_pc = 8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_pc", id_pc, 32'h8);
      chk("stl_i", id_instr, 32'h1000_0002);
      chk("stl_addr", rom_addr, 32'hC);
      chk("stl_cnt", icount, 32'd3);
    end
    stall = 1'b0;
    step(); chk("rel_pc", id_pc, 32'hC); chk("rel_i", id_instr, 32'h1000_0003);
            chk("rel_cnt", icount, 32'd4);
    // Asynchronous reset pulse between edges.
    #1 RST = 1'b1;
    #1;
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_pc", id_pc, RPC);
    chk("arst_cnt", icount, 32'd0);
    chk("arst_addr", rom_addr, RPC);
    step(); RST = 1'b0;
    step(); step();
    chk("arst_pc0", id_pc, 32'h0); chk("arst_c1", icount, 32'd1);
    step(); chk("arst_pc1", id_pc, 32'h4);
    // Redirect to a misaligned target while id_pc = 4.
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    step(); redirect = 1'b0;
    chk("rd_v", {31'd0, id_valid}, 32'd0); chk("rd_nop", id_instr, NOP);
    step(); chk("rd_pc", id_pc, 32'h40); chk("rd_i", id_instr, 32'h1000_0010);
            chk("rd_v1", {31'd0, id_valid}, 32'd1);
    step(); chk("rd_pc2", id_pc, 32'h44);
    // Redirect and stall together: redirect wins.
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0043;
    step(); redirect = 1'b0; stall = 1'b0;
    chk("rs_v", {31'd0, id_valid}, 32'd0);
    step(); chk("rs_pc", id_pc, 32'h40); chk("rs_i", id_instr, 32'h1000_0010);
    step(); chk("rs_pc2", id_pc, 32'h44);
    // Wrap of the fetch address.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0;
    step(); chk("wr_pc0", id_pc, 32'hFFFF_FFFC); chk("wr_i", id_instr, 32'h1000_003F);
            chk("wr_pc4", id_pc4, 32'h0);
    step(); chk("wr_pc1", id_pc, 32'h0);
    step(); chk("wr_pc2", id_pc, 32'h4);
    // Redirect in the first cycle after reset release.
    RST = 1'b1;
    step();
    RST = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    step(); redirect = 1'b0;
    step(); chk("rr_pc", id_pc, 32'h80); chk("rr_i", id_instr, 32'h1000_0020);
            chk("rr_cnt", icount, 32'd1);
    // Randomized phase, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(3) == 0);
      redirect = ($urandom_range(9) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                             : $urandom;
      if ($urandom_range(199) == 0) begin
        #1 RST = 1'b1;
        #1 RST = 1'b0;
      end
      step();
    end
    stall = 1'b0; redirect = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
